// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory backend port between the fetch requester
// and the load/store requester. Each granted request is registered onto the
// backend port and held there until the backend acknowledges it. The requester
// then gets a one-cycle acknowledge together with the captured read data.
// Ties are broken round-robin. A watchdog aborts a backend access that is never
// acknowledged and raises a sticky error flag.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rstn,
    // fetch requester
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    // load/store requester
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    // memory backend
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    // status
    output logic                err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value in the last BUSY cycle the backend is allowed to answer in.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    wait_cnt_reg, wait_cnt_next;
    logic                last_d_reg, last_d_next;

    logic                mem_req_reg, mem_req_next;
    logic                mem_we_reg, mem_we_next;
    logic [STRB_W-1:0]   mem_wstrb_reg, mem_wstrb_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;

    logic                i_ack_reg, i_ack_next;
    logic                d_ack_reg, d_ack_next;
    logic [DATA_W-1:0]   i_rdata_reg, i_rdata_next;
    logic [DATA_W-1:0]   d_rdata_reg, d_rdata_next;
    logic                err_reg, err_next;

    logic                grant_d;
    logic                grant_i;
    logic [STRB_W-1:0]   grant_wstrb;

    // Data wins a tie only if the previous grant went to fetch.
    assign grant_d = d_req & (~i_req | ~last_d_reg);
    assign grant_i = i_req & ~grant_d;

    // Byte enables only reach the backend for stores; loads present all zeros.
    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_wstrb
            assign grant_wstrb[gi] = d_we & d_wstrb[gi];
        end
    endgenerate

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        last_d_next    = last_d_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_wstrb_next = mem_wstrb_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        i_ack_next     = 1'b0;
        d_ack_next     = 1'b0;
        i_rdata_next   = i_rdata_reg;
        d_rdata_next   = d_rdata_reg;
        err_next       = err_reg;

        unique case (state_reg)
            IDLE: begin
                if (grant_d) begin
                    state_next     = BUSY_D;
                    last_d_next    = 1'b1;
                    wait_cnt_next  = '0;
                    mem_req_next   = 1'b1;
                    mem_we_next    = d_we;
                    mem_wstrb_next = grant_wstrb;
                    mem_addr_next  = d_addr;
                    mem_wdata_next = d_wdata;
                end else if (grant_i) begin
                    state_next     = BUSY_I;
                    last_d_next    = 1'b0;
                    wait_cnt_next  = '0;
                    mem_req_next   = 1'b1;
                    mem_we_next    = 1'b0;
                    mem_wstrb_next = '0;
                    mem_addr_next  = i_addr;
                    mem_wdata_next = '0;
                end
            end

            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    state_next   = RESP;
                    mem_req_next = 1'b0;
                    if (state_reg == BUSY_I) begin
                        i_ack_next   = 1'b1;
                        i_rdata_next = mem_rdata;
                    end else begin
                        d_ack_next = 1'b1;
                        if (!mem_we_reg) begin
                            d_rdata_next = mem_rdata;
                        end
                    end
                end else if (wait_cnt_reg == CNT_LAST) begin
                    // Abort: the requester sees an ordinary completion with zero data.
                    state_next   = RESP;
                    mem_req_next = 1'b0;
                    err_next     = 1'b1;
                    if (state_reg == BUSY_I) begin
                        i_ack_next   = 1'b1;
                        i_rdata_next = '0;
                    end else begin
                        d_ack_next = 1'b1;
                        if (!mem_we_reg) begin
                            d_rdata_next = '0;
                        end
                    end
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end

            RESP: begin
                // The ack pulse is live during this cycle. Requests are looked at again from IDLE.
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Registered backend port, requester responses, and bookkeeping.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wait_cnt_reg  <= '0;
            last_d_reg    <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_wstrb_reg <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            i_ack_reg     <= 1'b0;
            d_ack_reg     <= 1'b0;
            i_rdata_reg   <= '0;
            d_rdata_reg   <= '0;
            err_reg       <= 1'b0;
        end else begin
            wait_cnt_reg  <= wait_cnt_next;
            last_d_reg    <= last_d_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_wstrb_reg <= mem_wstrb_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            i_ack_reg     <= i_ack_next;
            d_ack_reg     <= d_ack_next;
            i_rdata_reg   <= i_rdata_next;
            d_rdata_reg   <= d_rdata_next;
            err_reg       <= err_next;
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_wstrb = mem_wstrb_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign i_ack     = i_ack_reg;
    assign i_rdata   = i_rdata_reg;
    assign d_ack     = d_ack_reg;
    assign d_rdata   = d_rdata_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed stimulus, a transaction-level
// reference model, a per-cycle compare process, and literal spot checks.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = DATA_W / 8;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [STRB_W-1:0] d_wstrb;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [STRB_W-1:0] mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              err;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .err(err)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // One outstanding transaction at most: who owns it, how long it has waited,
    // and whether its response cycle is the current one.
    bit                m_valid = 1'b0;
    int                m_owner = 0;     // 0 none, 1 fetch, 2 data
    int                m_age = 0;
    bit                m_resp = 1'b0;
    bit                m_last_data = 1'b0;
    bit                m_store = 1'b0;
    bit                m_bus_known = 1'b1;
    logic              e_mem_req, e_mem_we, e_i_ack, e_d_ack, e_err;
    logic [STRB_W-1:0] e_mem_wstrb;
    logic [ADDR_W-1:0] e_mem_addr;
    logic [DATA_W-1:0] e_mem_wdata, e_i_rdata, e_d_rdata;

    always @(posedge clk) begin
        cyc++;
        m_valid = 1'b1;
        if (!rstn) begin
            m_owner = 0; m_age = 0; m_resp = 1'b0; m_last_data = 1'b0;
            m_store = 1'b0; m_bus_known = 1'b1;
            e_mem_req = 1'b0; e_mem_we = 1'b0; e_mem_wstrb = '0;
            e_mem_addr = '0; e_mem_wdata = '0;
            e_i_ack = 1'b0; e_d_ack = 1'b0;
            e_i_rdata = '0; e_d_rdata = '0; e_err = 1'b0;
        end else begin
            e_i_ack = 1'b0;
            e_d_ack = 1'b0;
            if (m_resp) begin
                m_resp  = 1'b0;
                m_owner = 0;
            end else if (m_owner != 0) begin
                m_age++;
                if (mem_ack || m_age >= TIMEOUT) begin
                    e_mem_req   = 1'b0;
                    m_resp      = 1'b1;
                    m_bus_known = 1'b0;
                    if (!mem_ack) e_err = 1'b1;
                    if (m_owner == 1) begin
                        e_i_ack   = 1'b1;
                        e_i_rdata = mem_ack ? mem_rdata : '0;
                    end else begin
                        e_d_ack = 1'b1;
                        if (!m_store) e_d_rdata = mem_ack ? mem_rdata : '0;
                    end
                end
            end else if (i_req || d_req) begin
                if (d_req && (!i_req || !m_last_data)) begin
                    m_owner = 2; m_last_data = 1'b1; m_store = d_we;
                    e_mem_we    = d_we;
                    e_mem_wstrb = d_we ? d_wstrb : '0;
                    e_mem_addr  = d_addr;
                    e_mem_wdata = d_wdata;
                end else begin
                    m_owner = 1; m_last_data = 1'b0; m_store = 1'b0;
                    e_mem_we    = 1'b0;
                    e_mem_wstrb = '0;
                    e_mem_addr  = i_addr;
                    e_mem_wdata = '0;
                end
                m_age     = 0;
                e_mem_req = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("mem_req", mem_req, e_mem_req);
            chk("i_ack", i_ack, e_i_ack);
            chk("d_ack", d_ack, e_d_ack);
            chk("i_rdata", i_rdata, e_i_rdata);
            chk("d_rdata", d_rdata, e_d_rdata);
            chk("err", err, e_err);
            if (e_mem_req || m_bus_known) begin
                chk("mem_we", mem_we, e_mem_we);
                chk("mem_wstrb", mem_wstrb, e_mem_wstrb);
                chk("mem_addr", mem_addr, e_mem_addr);
                chk("mem_wdata", mem_wdata, e_mem_wdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rstn = 1'b0;
        repeat (n) step();
        rstn = 1'b1;
    endtask

    logic [ADDR_W-1:0] order_exp [4];
    int reqcnt;
    int ackcyc;
    bit seen;

    initial begin
        rstn = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_wstrb = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        do_reset(3);
        chk("reset_mem_req", mem_req, 1'b0);
        chk("reset_err", err, 1'b0);
        step();

        // Fetch only: ack in cycle 3.
        i_req = 1'b1; i_addr = 32'h100;
        step();
        chk("fetch_c1_req", mem_req, 1'b1);
        chk("fetch_c1_addr", mem_addr, 32'h100);
        chk("fetch_c1_we", mem_we, 1'b0);
        step();
        step();
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        $display("fetch: i_ack=%0b i_rdata=%h", i_ack, i_rdata);
        chk("fetch_c4_iack", i_ack, 1'b1);
        chk("fetch_c4_rdata", i_rdata, 32'hDEADBEEF);
        chk("fetch_c4_req", mem_req, 1'b0);
        chk("fetch_c4_dack", d_ack, 1'b0);
        i_req = 1'b0;
        step();
        chk("fetch_c5_iack", i_ack, 1'b0);

        // Load: ack in cycle 1.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_wdata = 32'hAAAA5555; d_wstrb = 4'hF;
        step();
        chk("load_wstrb", mem_wstrb, 4'h0);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        step();
        mem_ack = 1'b0;
        $display("load: d_ack=%0b d_rdata=%h", d_ack, d_rdata);
        chk("load_dack", d_ack, 1'b1);
        chk("load_rdata", d_rdata, 32'hCAFEF00D);
        d_req = 1'b0;
        step();

        // Store: inputs change mid-transaction; ack in cycle 2.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_wstrb = 4'b0011;
        step();
        chk("store_we", mem_we, 1'b1);
        chk("store_wstrb", mem_wstrb, 4'b0011);
        chk("store_addr", mem_addr, 32'h2000);
        chk("store_wdata", mem_wdata, 32'h12345678);
        d_addr = 32'hFFFFFFFF; d_wdata = 32'h0;
        step();
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        step();
        mem_ack = 1'b0;
        $display("store: d_ack=%0b d_rdata=%h", d_ack, d_rdata);
        chk("store_dack", d_ack, 1'b1);
        chk("store_rdata_kept", d_rdata, 32'hCAFEF00D);
        d_req = 1'b0;
        step();

        // Spurious backend ack while idle.
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        step();
        mem_ack = 1'b0;
        $display("spurious: i_ack=%0b d_ack=%0b", i_ack, d_ack);
        chk("spur_iack", i_ack, 1'b0);
        chk("spur_dack", d_ack, 1'b0);
        chk("spur_irdata", i_rdata, 32'hDEADBEEF);
        chk("spur_drdata", d_rdata, 32'hCAFEF00D);
        step();

        // Timeout: a load that is never acknowledged.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_wstrb = '0;
        reqcnt = 0; ackcyc = 0;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (mem_req) reqcnt++;
            if (d_ack) begin
                ackcyc = c;
                d_req  = 1'b0;
            end
        end
        $display("timeout: req_cycles=%0d ack_cycle=%0d err=%0b", reqcnt, ackcyc, err);
        chk("to_req_cycles", reqcnt, 4);
        chk("to_ack_cycle", ackcyc, 5);
        chk("to_rdata", d_rdata, 32'h0);
        chk("to_err", err, 1'b1);
        repeat (3) step();
        chk("to_err_sticky", err, 1'b1);

        // Reset in the middle of a load, then a late backend ack.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
        step();
        chk("mid_req", mem_req, 1'b1);
        step();
        rstn = 1'b0; d_req = 1'b0;
        step();
        rstn = 1'b1;
        step();
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        step();
        mem_ack = 1'b0;
        $display("mid-reset: mem_req=%0b d_ack=%0b err=%0b", mem_req, d_ack, err);
        chk("mid_mem_req", mem_req, 1'b0);
        chk("mid_dack", d_ack, 1'b0);
        chk("mid_drdata", d_rdata, 32'h0);
        chk("mid_irdata", i_rdata, 32'h0);
        chk("mid_err", err, 1'b0);
        chk("mid_addr", mem_addr, 32'h0);
        step();

        // Both requesters held for four transactions: expect D, I, D, I.
        order_exp[0] = 32'h80; order_exp[1] = 32'h40;
        order_exp[2] = 32'h80; order_exp[3] = 32'h40;
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        for (int t = 0; t < 4; t++) begin
            seen = 1'b0;
            for (int w = 0; w < 8 && !seen; w++) begin
                step();
                if (mem_req) seen = 1'b1;
            end
            if (!seen) begin
                checks++;
                fails++;
                $display("FAIL rr_wait: no mem_req for grant %0d, expected one within 8 cycles", t);
            end
            $display("round-robin grant %0d: mem_addr=%h", t, mem_addr);
            chk("rr_order", mem_addr, order_exp[t]);
            mem_ack = 1'b1; mem_rdata = 32'h1000 + t;
            step();
            mem_ack = 1'b0;
            if (order_exp[t] == 32'h80) chk("rr_dack", d_ack, 1'b1);
            else                        chk("rr_iack", i_ack, 1'b1);
            if (t == 3) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
        end
        repeat (3) step();
        chk("rr_final_irdata", i_rdata, 32'h1003);
        chk("rr_final_drdata", d_rdata, 32'h1002);
        chk("rr_idle_req", mem_req, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single unified memory port between the instruction-fetch requester (FETCH state) and the load/store requester (MEMREAD/MEMWRITE states). Sits between the multicycle control/datapath and the memory backend. Registers each granted request, holds the backend request until acknowledged, and returns a one-cycle acknowledge with captured read data. Round-robin arbitration and a bounded-wait watchdog.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles waiting for mem_ack before abort (must be ≥1)
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- i_req  in  1  fetch request; held with i_addr stable until i_ack
- i_addr  in  ADDR_W  fetch address
- i_ack  out  1  one-cycle pulse: fetch done, i_rdata valid
- i_rdata  out  DATA_W  fetch data; held until the next fetch completes
- d_req  in  1  load/store request; held with d_* stable until d_ack
- d_we  in  1  1 = store, 0 = load
- d_wstrb  in  DATA_W/8  byte write enables; ignored for loads
- d_addr  in  ADDR_W  load/store address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle pulse: load/store done
- d_rdata  out  DATA_W  load data; held until the next load completes
- mem_req  out  1  backend request; held until mem_ack
- mem_we  out  1  backend write enable
- mem_wstrb  out  DATA_W/8  backend byte enables; all 0 on reads
- mem_addr  out  ADDR_W  backend address
- mem_wdata  out  DATA_W  backend write data
- mem_rdata  in  DATA_W  backend read data, valid with mem_ack
- mem_ack  in  1  backend completion, one-cycle pulse
- err  out  1  sticky timeout flag; cleared only by reset

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: no request → stay. Only i_req → BUSY_I. Only d_req → BUSY_D. Both → grant the requester not served last (last_d flag; reset value 0, so data wins the first tie).
- On grant: register addr/we/wstrb/wdata into mem_* outputs, set mem_req=1, clear wait counter, update last_d (1 on a data grant, 0 on a fetch grant). Fetch grants drive mem_we=0, mem_wstrb=0, mem_wdata=0.
- BUSY_x: mem_req held, mem_* stable. On mem_ack: mem_req=0; for fetch or load, capture mem_rdata into i_rdata/d_rdata; → RESP.
- Wait counter increments each BUSY cycle without mem_ack. When it reaches TIMEOUT: mem_req=0, err=1, targeted rdata register loaded with 0, → RESP (abort looks like completion to the requester).
- RESP: pulse x_ack for exactly one cycle → IDLE. Requester must deassert x_req in the cycle after x_ack, or a new transaction is issued.
- mem_ack in IDLE or RESP: ignored, no state change.
- Changes on i_*/d_* inputs during BUSY/RESP have no effect; registered copies are used.
- Reset (any state, including mid-transaction): state=IDLE, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, i_ack=d_ack=0, i_rdata=d_rdata=0, err=0, last_d=0, counter=0. A backend ack arriving after reset is ignored.

## Timing
- Request seen in IDLE at cycle 0 → mem_req high from cycle 1 (registered outputs).
- mem_ack at cycle k (k≥1) → mem_req low at k+1; x_ack high at k+1 with rdata valid; IDLE at k+2.
- Minimum turnaround 3 cycles per transaction (ack at cycle 1). Back-to-back requests: next grant decided in IDLE at k+2, mem_req at k+3.
- Timeout: no mem_ack in cycles 1..TIMEOUT → abort at cycle TIMEOUT+1, x_ack at TIMEOUT+1.
- Outputs driven only from registers; no combinational input-to-output paths.

## Test plan
- Fetch only: i_addr=0x100, mem_ack at cycle 3 with mem_rdata=0xDEADBEEF → mem_req cycles 1–3, mem_we=0, i_ack at cycle 4 only, i_rdata=0xDEADBEEF; d_ack stays 0.
- Store: d_we=1, d_addr=0x2000, d_wdata=0x12345678, d_wstrb=4'b0011 → mem_* match exactly while mem_req high; d_ack one cycle after mem_ack; d_rdata unchanged.
- Simultaneous i_req and d_req held for 4 transactions after reset → grant order D, I, D, I; no starvation.
- Timeout: TIMEOUT=4, never ack a load → mem_req cycles 1–4, low at 5, d_ack at 5, d_rdata=0, err=1 held until rstn=0.
- Reset mid-transaction: rstn=0 in BUSY_D, then mem_ack the cycle after release → all outputs at reset values, no ack pulse, state IDLE.
- Spurious mem_ack in IDLE with no requests → no ack pulse, rdata registers and err unchanged.
